dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_store.sv | 24 ++
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the doubleword data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } dmem_state_e;

   localparam int unsigned WORD_BYTES  = 8;
   localparam int unsigned OFFSET_BITS = $clog2(WORD_BYTES);
   // Wide enough for the largest legal LATENCY of 15.
   localparam int unsigned CNT_WIDTH   = 4;

endpackage

// File: rtl/dmem_store.sv
// DMEM_DEPTH x 64 storage array: synchronous write, combinational indexed read.
module dmem_store #(
   parameter int unsigned DMEM_DEPTH      = 1024,
   parameter int unsigned DMEM_ADDR_WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [DMEM_ADDR_WIDTH-1:0] idx,
   input  logic [63:0]                wdata,
   output logic [63:0]                rdata
);

   logic [63:0] mem [DMEM_DEPTH];

   // No reset: contents persist across reset_b.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding 64-bit load/store with a fixed
// programmable latency, valid/ready on both request and response sides.
module dmem_responder #(
   parameter int unsigned DMEM_DEPTH      = 1024,
   parameter int unsigned DMEM_ADDR_WIDTH = 10,
   parameter int unsigned LATENCY         = 2
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   import dmem_pkg::*;

   dmem_state_e          state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 write_q;
   logic [63:0]          addr_q;
   logic [63:0]          wdata_q;
   logic [63:0]          rdata_q, rdata_d;
   logic                 err_q, err_d;

   logic                       accept;
   logic                       access_err;
   logic                       mem_we;
   logic [63:0]                mem_rdata;
   logic [DMEM_ADDR_WIDTH-1:0] mem_idx;

   assign mem_idx    = addr_q[DMEM_ADDR_WIDTH+OFFSET_BITS-1:OFFSET_BITS];
   assign access_err = (addr_q[OFFSET_BITS-1:0] != '0) ||
                       (addr_q[63:OFFSET_BITS] >= (64-OFFSET_BITS)'(DMEM_DEPTH));
   assign accept     = (state_q == IDLE) && req_valid;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      mem_we     = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = BUSY;
               cnt_d   = CNT_WIDTH'(LATENCY - 1);
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               err_d   = access_err;
               rdata_d = (access_err || write_q) ? 64'd0 : mem_rdata;
               mem_we  = write_q && !access_err;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   dmem_store #(
      .DMEM_DEPTH     (DMEM_DEPTH),
      .DMEM_ADDR_WIDTH(DMEM_ADDR_WIDTH)
   ) u_store (
      .clk  (clk),
      .we   (mem_we),
      .idx  (mem_idx),
      .wdata(wdata_q),
      .rdata(mem_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: scoreboarded transactions on a LATENCY=2 responder, plus a
// LATENCY=1 instance for back-to-back spacing.
module tb_dmem_responder;

   localparam int unsigned LAT = 2;

   logic        clk;
   logic        reset_b;

   logic        req_valid, req_ready, req_write;
   logic [63:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [63:0] resp_rdata;

   logic        b_req_valid, b_req_ready, b_req_write;
   logic [63:0] b_req_addr, b_req_wdata;
   logic        b_resp_valid, b_resp_ready, b_resp_err;
   logic [63:0] b_resp_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   logic [64:0] sb_q[$];   // {err, rdata}

   dmem_responder #(
      .DMEM_DEPTH     (1024),
      .DMEM_ADDR_WIDTH(10),
      .LATENCY        (LAT)
   ) u_dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err)
   );

   dmem_responder #(
      .DMEM_DEPTH     (1024),
      .DMEM_ADDR_WIDTH(10),
      .LATENCY        (1)
   ) u_dut_l1 (
      .clk       (clk),
      .reset_b   (reset_b),
      .req_valid (b_req_valid),
      .req_ready (b_req_ready),
      .req_write (b_req_write),
      .req_addr  (b_req_addr),
      .req_wdata (b_req_wdata),
      .resp_valid(b_resp_valid),
      .resp_ready(b_resp_ready),
      .resp_rdata(b_resp_rdata),
      .resp_err  (b_resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One request on the LATENCY=2 instance; stall holds resp_ready low for that many edges.
   task automatic transact(input string tag, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] exp_rd,
                           input logic exp_err, input int stall);
      int          n;
      logic [64:0] exp;
      sb_q.push_back({exp_err, exp_rd});
      resp_ready = (stall == 0);
      req_write  = wr;
      req_addr   = addr;
      req_wdata  = wdata;
      req_valid  = 1'b1;
      check({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
      step();
      req_valid = 1'b0;
      check({tag, " req_ready busy"}, 64'(req_ready), 64'd0);
      n = 0;
      while (!resp_valid && n < 50) begin
         step();
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'(LAT));
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 65'h1_ffff_ffff_ffff_ffff;
      check({tag, " rdata"}, resp_rdata, exp[63:0]);
      check({tag, " err"}, 64'(resp_err), 64'(exp[64]));
      for (int i = 0; i < stall; i++) begin
         step();
         check({tag, " stall valid"}, 64'(resp_valid), 64'd1);
         check({tag, " stall rdata"}, resp_rdata, exp[63:0]);
         check({tag, " stall req_ready"}, 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      step();
      check({tag, " post valid"}, 64'(resp_valid), 64'd0);
      check({tag, " post req_ready"}, 64'(req_ready), 64'd1);
   endtask

   initial begin
      logic [64:0] exp;
      reset_b      = 1'b0;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      resp_ready   = 1'b1;
      b_req_valid  = 1'b0;
      b_req_write  = 1'b0;
      b_req_addr   = '0;
      b_req_wdata  = '0;
      b_resp_ready = 1'b1;

      repeat (3) step();
      reset_b = 1'b1;
      step();
      check("reset req_ready", 64'(req_ready), 64'd1);
      check("reset resp_valid", 64'(resp_valid), 64'd0);
      check("reset resp_rdata", resp_rdata, 64'd0);
      check("reset resp_err", 64'(resp_err), 64'd0);

      transact("sd 0x10", 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0, 0);
      transact("ld 0x10", 1'b0, 64'h10, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0);

      transact("sd 0x0", 1'b1, 64'h0, 64'h11112222_33334444, 64'd0, 1'b0, 0);
      transact("ld 0x13", 1'b0, 64'h13, 64'd0, 64'd0, 1'b1, 0);
      transact("sd 0x2000", 1'b1, 64'h2000, 64'hBAD0BAD0_BAD0BAD0, 64'd0, 1'b1, 0);
      transact("ld 0x0", 1'b0, 64'h0, 64'd0, 64'h11112222_33334444, 1'b0, 0);
      transact("sd 0x1ff8", 1'b1, 64'h1FF8, 64'h55AA55AA_00FF00FF, 64'd0, 1'b0, 0);
      transact("ld 0x1ff8", 1'b0, 64'h1FF8, 64'd0, 64'h55AA55AA_00FF00FF, 1'b0, 0);
      transact("ld high", 1'b0, 64'h8000_0000_0000_0010, 64'd0, 64'd0, 1'b1, 0);

      transact("sd 0x8", 1'b1, 64'h8, 64'h01234567_89ABCDEF, 64'd0, 1'b0, 0);
      transact("ld 0x8 stall", 1'b0, 64'h8, 64'd0, 64'h01234567_89ABCDEF, 1'b0, 5);

      // Reset one cycle into BUSY must abandon the store.
      transact("sd 0x18 prior", 1'b1, 64'h18, 64'hAAAA5555_AAAA5555, 64'd0, 1'b0, 0);
      req_write = 1'b1;
      req_addr  = 64'h18;
      req_wdata = 64'h1234;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      reset_b   = 1'b0;
      #1;
      check("mid-busy reset req_ready", 64'(req_ready), 64'd1);
      check("mid-busy reset resp_valid", 64'(resp_valid), 64'd0);
      step();
      step();
      reset_b = 1'b1;
      step();
      check("after reset resp_valid", 64'(resp_valid), 64'd0);
      transact("ld 0x18", 1'b0, 64'h18, 64'd0, 64'hAAAA5555_AAAA5555, 1'b0, 0);

      // LATENCY=1, req_valid held: accept, BUSY, RESP repeating every 3 cycles.
      for (int k = 0; k < 12; k++) begin
         if (k > 0) begin
            check($sformatf("l1 req_ready k=%0d", k), 64'(b_req_ready),
                  64'((k % 3) == 0));
            check($sformatf("l1 resp_valid k=%0d", k), 64'(b_resp_valid),
                  64'((k % 3) == 2));
            if ((k % 3) == 2) begin
               exp = (sb_q.size() > 0) ? sb_q.pop_front() : 65'h1_ffff_ffff_ffff_ffff;
               check($sformatf("l1 rdata k=%0d", k), b_resp_rdata, exp[63:0]);
               check($sformatf("l1 err k=%0d", k), 64'(b_resp_err), 64'(exp[64]));
            end
         end
         if ((k % 3) == 0) begin
            sb_q.push_back({1'b0, 64'd0});
         end
         b_req_valid = 1'b1;
         b_req_write = 1'b1;
         b_req_addr  = 64'(8 * k);
         b_req_wdata = 64'(k);
         step();
      end
      b_req_valid = 1'b0;
      check("l1 idle req_ready", 64'(b_req_ready), 64'd1);
      sb_q.push_back({1'b0, 64'd3});
      b_req_write = 1'b0;
      b_req_addr  = 64'h18;
      b_req_valid = 1'b1;
      step();
      b_req_valid = 1'b0;
      step();
      check("l1 ld valid", 64'(b_resp_valid), 64'd1);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 65'h1_ffff_ffff_ffff_ffff;
      check("l1 ld word3 rdata", b_resp_rdata, exp[63:0]);
      check("l1 ld word3 err", 64'(b_resp_err), 64'(exp[64]));
      step();
      check("scoreboard drained", 64'(sb_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
